mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle instruction sequencer (Moore FSM) for a RISC-V style core.
//
// Optional feature macro: MC_JAL_EN
//   defined   -> jal (op 1101111) is decoded and sequenced through the JAL state
//   undefined -> jal is treated as an unsupported opcode and lands in ILLEGAL
//
// Ports
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  synchronous active-low reset
//   op          in   7  opcode from instruction register
//   funct3      in   3  instruction funct3
//   funct7b5    in   1  instruction bit 30
//   zero        in   1  ALU zero flag
//   mem_ready   in   1  memory completes the current access this cycle
//   mem_req     out  1  memory access request, held until mem_ready
//   pcwrite     out  1  PC write strobe
//   adrsrc      out  1  memory address select
//   memwrite    out  1  memory write strobe
//   irwrite     out  1  instruction register write strobe
//   regwrite    out  1  register file write strobe
//   resultsrc   out  2  result mux select
//   alusrca     out  2  ALU A mux select
//   alusrcb     out  2  ALU B mux select
//   immsrc      out  2  immediate format select (from op only)
//   alucontrol  out  3  ALU operation
//   illegal     out  1  sticky unsupported-opcode flag
//   state       out  4  current state code (debug)
//
// state    | meaning
// ---------+----------------------------------------------------
// FETCH    | request instruction word, bump PC when it arrives
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | compute load/store effective address
// MEMREAD  | load access in progress
// MEMWB    | write loaded data to register file
// MEMWRITE | store access in progress
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | write ALU result to register file
// BEQ      | compare, take branch on zero
// JAL      | jump, link address routed via ALUWB
// ILLEGAL  | unsupported opcode, parked until reset
//
// The strobes depend on mem_ready (FETCH) and zero (BEQ) within the same cycle
// and must drop the moment rst_n goes low, so outputs are decoded combinationally
// from the registered state rather than registered themselves.

module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q;
  logic   illegal_q;

  logic       mem_req_d, pcwrite_d, memwrite_d, irwrite_d, regwrite_d;
  logic [2:0] funct_alu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYP:      state_q <= S_EXECR;
            OP_ITYP:      state_q <= S_EXECI;
            OP_BEQ:       state_q <= S_BEQ;
`ifdef MC_JAL_EN
            OP_JAL:       state_q <= S_JAL;
`endif
            default: begin
              state_q   <= S_ILLEGAL;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // op[5] separates sw (0100011) from lw (0000011)
        S_MEMADR:   state_q <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:    state_q <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECR:    state_q <= S_ALUWB;
        S_EXECI:    state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BEQ:      state_q <= S_FETCH;
        S_JAL:      state_q <= S_ALUWB;
        S_ILLEGAL:  state_q <= S_ILLEGAL;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Subtract only for R-type (op[5]=1) with bit 30 set; addi never subtracts.
  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (op)
      OP_LW, OP_ITYP: immsrc = 2'b00;
      OP_SW:          immsrc = 2'b01;
      OP_BEQ:         immsrc = 2'b10;
`ifdef MC_JAL_EN
      OP_JAL:         immsrc = 2'b11;
`endif
      default:        immsrc = 2'b00;
    endcase
  end

  always_comb begin
    mem_req_d  = 1'b0;
    pcwrite_d  = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    regwrite_d = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_d = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite_d = mem_ready;
        pcwrite_d = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_d = 1'b1;
        adrsrc    = 1'b1;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_d = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_d  = 1'b1;
        adrsrc     = 1'b1;
        memwrite_d = 1'b1;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = funct_alu;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = funct_alu;
      end
      S_ALUWB: regwrite_d = 1'b1;
      S_BEQ: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        pcwrite_d  = zero;
      end
      S_JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  // A pending access is abandoned as soon as reset is asserted, not at the edge.
  assign mem_req  = rst_n & mem_req_d;
  assign pcwrite  = rst_n & pcwrite_d;
  assign memwrite = rst_n & memwrite_d;
  assign irwrite  = rst_n & irwrite_d;
  assign regwrite = rst_n & regwrite_d;
  assign illegal  = illegal_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through the
// sequencer and checks state codes and control outputs against hand values.

module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;
  int irw_cnt = 0;
  int rw_cnt  = 0;
  int mw_cnt  = 0;
  int base;

  logic [2:0] f3_vec [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
  logic [2:0] alu_exp[4] = '{3'b001, 3'b101, 3'b011, 3'b010};

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pcwrite(pcwrite),
    .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always @(negedge clk) begin
    if (irwrite)  irw_cnt++;
    if (regwrite) rw_cnt++;
    if (memwrite) mw_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic mr, input logic z, input logic [3:0] exp_state, input string tag);
    mem_ready = mr;
    zero      = z;
    #1;
    check({tag, "_state"}, 32'(state), 32'(exp_state));
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    tick;
    tick;
    #1;
    check("rst_state",   32'(state), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_memreq",  32'(mem_req), 32'd0);
    check("rst_irwrite", 32'(irwrite), 32'd0);
    check("rst_pcwrite", 32'(pcwrite), 32'd0);

    // lw, instruction memory stalls two cycles
    rst_n = 1'b1; op = 7'b0000011; funct3 = 3'b010;
    cyc(1'b0, 1'b0, 4'd0, "lw_f1");
    check("lw_f1_memreq", 32'(mem_req), 32'd1);
    check("lw_f1_irw",    32'(irwrite), 32'd0);
    check("lw_f1_pcw",    32'(pcwrite), 32'd0);
    tick;
    cyc(1'b0, 1'b0, 4'd0, "lw_f2");
    check("lw_f2_irw", 32'(irwrite), 32'd0);
    tick;
    cyc(1'b1, 1'b0, 4'd0, "lw_f3");
    check("lw_f3_irw",  32'(irwrite), 32'd1);
    check("lw_f3_pcw",  32'(pcwrite), 32'd1);
    check("lw_f3_srcb", 32'(alusrcb), 32'd2);
    check("lw_f3_res",  32'(resultsrc), 32'd2);
    tick;
    cyc(1'b1, 1'b0, 4'd1, "lw_dec");
    check("lw_dec_srca", 32'(alusrca), 32'd1);
    check("lw_dec_srcb", 32'(alusrcb), 32'd1);
    check("lw_dec_imm",  32'(immsrc), 32'd0);
    check("lw_dec_irw",  32'(irwrite), 32'd0);
    check("lw_irw_pulses", 32'(irw_cnt), 32'd1);
    tick;
    cyc(1'b1, 1'b0, 4'd2, "lw_adr");
    check("lw_adr_srca", 32'(alusrca), 32'd2);
    check("lw_adr_srcb", 32'(alusrcb), 32'd1);
    check("lw_adr_alu",  32'(alucontrol), 32'd0);
    tick;
    cyc(1'b0, 1'b0, 4'd3, "lw_rd1");
    check("lw_rd1_memreq", 32'(mem_req), 32'd1);
    check("lw_rd1_adrsrc", 32'(adrsrc), 32'd1);
    tick;
    cyc(1'b1, 1'b0, 4'd3, "lw_rd2");
    tick;
    cyc(1'b1, 1'b0, 4'd4, "lw_wb");
    check("lw_wb_regw", 32'(regwrite), 32'd1);
    check("lw_wb_res",  32'(resultsrc), 32'd1);
    tick;
    check("lw_regw_pulses", 32'(rw_cnt), 32'd1);

    // sw, memory always ready
    op = 7'b0100011;
    base = mw_cnt;
    cyc(1'b1, 1'b0, 4'd0, "sw_f");
    tick;
    cyc(1'b1, 1'b0, 4'd1, "sw_dec");
    check("sw_dec_imm", 32'(immsrc), 32'd1);
    tick;
    cyc(1'b1, 1'b0, 4'd2, "sw_adr");
    tick;
    cyc(1'b1, 1'b0, 4'd5, "sw_wr");
    check("sw_wr_memw",   32'(memwrite), 32'd1);
    check("sw_wr_memreq", 32'(mem_req), 32'd1);
    check("sw_wr_adrsrc", 32'(adrsrc), 32'd1);
    tick;
    check("sw_memw_pulses", 32'(mw_cnt - base), 32'd1);

    // R-type funct decode
    for (int i = 0; i < 4; i++) begin
      op = 7'b0110011; funct3 = f3_vec[i]; funct7b5 = 1'b1;
      cyc(1'b1, 1'b0, 4'd0, "r_f");
      tick;
      cyc(1'b1, 1'b0, 4'd1, "r_dec");
      tick;
      cyc(1'b1, 1'b0, 4'd6, "r_ex");
      check("r_ex_alu",  32'(alucontrol), 32'(alu_exp[i]));
      check("r_ex_srca", 32'(alusrca), 32'd2);
      check("r_ex_srcb", 32'(alusrcb), 32'd0);
      tick;
      cyc(1'b1, 1'b0, 4'd8, "r_wb");
      check("r_wb_regw", 32'(regwrite), 32'd1);
      check("r_wb_res",  32'(resultsrc), 32'd0);
      tick;
    end

    // addi with bit 30 set must still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    cyc(1'b1, 1'b0, 4'd0, "i_f");
    tick;
    cyc(1'b1, 1'b0, 4'd1, "i_dec");
    check("i_dec_imm", 32'(immsrc), 32'd0);
    tick;
    cyc(1'b1, 1'b0, 4'd7, "i_ex");
    check("i_ex_alu",  32'(alucontrol), 32'd0);
    check("i_ex_srcb", 32'(alusrcb), 32'd1);
    tick;
    cyc(1'b1, 1'b0, 4'd8, "i_wb");
    tick;

    // beq taken / not taken
    for (int z = 1; z >= 0; z--) begin
      op = 7'b1100011; funct7b5 = 1'b0;
      cyc(1'b1, 1'b0, 4'd0, "beq_f");
      tick;
      cyc(1'b1, 1'b0, 4'd1, "beq_dec");
      check("beq_dec_imm", 32'(immsrc), 32'd2);
      tick;
      cyc(1'b1, 1'(z), 4'd9, "beq_ex");
      check("beq_pcw", 32'(pcwrite), 32'(z));
      check("beq_alu", 32'(alucontrol), 32'd1);
      tick;
      cyc(1'b1, 1'b0, 4'd0, "beq_ret");
    end

    // jal
    op = 7'b1101111;
    cyc(1'b1, 1'b0, 4'd0, "jal_f");
    tick;
    cyc(1'b1, 1'b0, 4'd1, "jal_dec");
`ifdef MC_JAL_EN
    check("jal_dec_imm", 32'(immsrc), 32'd3);
    tick;
    cyc(1'b1, 1'b0, 4'd10, "jal_ex");
    check("jal_pcw",  32'(pcwrite), 32'd1);
    check("jal_srca", 32'(alusrca), 32'd1);
    check("jal_srcb", 32'(alusrcb), 32'd2);
    tick;
    cyc(1'b1, 1'b0, 4'd8, "jal_wb");
    tick;
`else
    check("jal_dec_imm", 32'(immsrc), 32'd0);
    tick;
    cyc(1'b1, 1'b0, 4'd11, "jal_ill");
    check("jal_illegal", 32'(illegal), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
`endif

    // unsupported opcode parks in ILLEGAL until reset
    op = 7'b0000000;
    cyc(1'b1, 1'b0, 4'd0, "ill_f");
    check("ill_f_illegal", 32'(illegal), 32'd0);
    tick;
    cyc(1'b1, 1'b0, 4'd1, "ill_dec");
    tick;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 4'd11, "ill_hold");
      check("ill_memreq",  32'(mem_req), 32'd0);
      check("ill_illegal", 32'(illegal), 32'd1);
      check("ill_pcw",     32'(pcwrite), 32'd0);
      tick;
    end
    rst_n = 1'b0;
    #1;
    check("ill_pre_edge", 32'(illegal), 32'd1);
    tick;
    check("ill_rst_state",   32'(state), 32'd0);
    check("ill_rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    // reset during a stalled load abandons the access
    op = 7'b0000011;
    cyc(1'b1, 1'b0, 4'd0, "ab_f");
    tick;
    cyc(1'b1, 1'b0, 4'd1, "ab_dec");
    tick;
    cyc(1'b1, 1'b0, 4'd2, "ab_adr");
    tick;
    cyc(1'b0, 1'b0, 4'd3, "ab_rd");
    check("ab_rd_memreq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ab_rst_memreq", 32'(mem_req), 32'd0);
    check("ab_rst_hold",   32'(state), 32'd3);
    tick;
    check("ab_rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ab_refetch_memreq", 32'(mem_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
